// File: rtl/aiu_mac_sequencer.sv
// aiu_mac_sequencer: runs OUTDATANUM dot products of INPDATANUM signed words
// against a weight memory and keeps the saturated (optionally ReLU'd) results
// in a small result memory readable at any time.
module aiu_mac_sequencer #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned INPDATANUM = 8,
  parameter int unsigned OUTDATANUM = 4,
  parameter int unsigned FRACBITS   = 0,
  localparam int unsigned INPADRWIDTH = $clog2(INPDATANUM),
  localparam int unsigned OUTADRWIDTH = $clog2(OUTDATANUM),
  localparam int unsigned WGTADRWIDTH = $clog2(INPDATANUM * OUTDATANUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   waitSt,
  output logic                   waitFin,
  input  logic                   cfg_relu,
  output logic [INPADRWIDTH-1:0] inp_adr,
  input  logic [DATAWIDTH-1:0]   inp_data,
  output logic [WGTADRWIDTH-1:0] wgt_adr,
  input  logic [DATAWIDTH-1:0]   wgt_data,
  input  logic [OUTADRWIDTH-1:0] out_adr,
  output logic [DATAWIDTH-1:0]   out_data,
  output logic                   busy
);

  // Accumulator is wide enough to hold INPDATANUM full-scale products exactly.
  localparam int unsigned PRODWIDTH = 2 * DATAWIDTH;
  localparam int unsigned ACCWIDTH  = PRODWIDTH + INPADRWIDTH;
  localparam int unsigned OUTSLOTS  = 2 ** OUTADRWIDTH;

  localparam logic [INPADRWIDTH-1:0] IC_LAST = INPADRWIDTH'(INPDATANUM - 1);
  localparam logic [OUTADRWIDTH-1:0] OC_LAST = OUTADRWIDTH'(OUTDATANUM - 1);
  localparam logic [WGTADRWIDTH-1:0] WGT_ROW = WGTADRWIDTH'(INPDATANUM);

  localparam logic signed [ACCWIDTH-1:0] SAT_MAX =
    {{(ACCWIDTH - DATAWIDTH + 1){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
  localparam logic signed [ACCWIDTH-1:0] SAT_MIN =
    {{(ACCWIDTH - DATAWIDTH + 1){1'b1}}, {(DATAWIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       state, state_nxt;
  logic [INPADRWIDTH-1:0]       ic, ic_nxt;
  logic [OUTADRWIDTH-1:0]       oc, oc_nxt;
  logic signed [ACCWIDTH-1:0]   acc, acc_nxt;
  logic                         relu_q, relu_nxt;
  logic                         res_we;

  logic signed [PRODWIDTH-1:0]  prod;
  logic signed [ACCWIDTH-1:0]   acc_shifted;
  logic [DATAWIDTH-1:0]         res_sat;
  logic [DATAWIDTH-1:0]         res_val;

  logic [DATAWIDTH-1:0]         result   [OUTDATANUM];
  logic [DATAWIDTH-1:0]         rd_table [OUTSLOTS];

  // Signed product of the current input word and weight.
  always_comb begin
    prod = PRODWIDTH'($signed(inp_data)) * PRODWIDTH'($signed(wgt_data));
  end

  // Scale, saturate to the signed word range, then apply the latched ReLU.
  always_comb begin
    acc_shifted = acc >>> FRACBITS;
    if (acc_shifted > SAT_MAX) begin
      res_sat = SAT_MAX[DATAWIDTH-1:0];
    end else if (acc_shifted < SAT_MIN) begin
      res_sat = SAT_MIN[DATAWIDTH-1:0];
    end else begin
      res_sat = acc_shifted[DATAWIDTH-1:0];
    end
    res_val = (relu_q && res_sat[DATAWIDTH-1]) ? '0 : res_sat;
  end

  // Sequencer state, counters, accumulator and latched ReLU flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ic     <= '0;
      oc     <= '0;
      acc    <= '0;
      relu_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ic     <= ic_nxt;
      oc     <= oc_nxt;
      acc    <= acc_nxt;
      relu_q <= relu_nxt;
    end
  end

  // Next-state, datapath updates and handshake/address outputs.
  always_comb begin
    state_nxt = state;
    ic_nxt    = ic;
    oc_nxt    = oc;
    acc_nxt   = acc;
    relu_nxt  = relu_q;
    res_we    = 1'b0;
    waitFin   = 1'b0;
    busy      = 1'b1;
    inp_adr   = '0;
    wgt_adr   = '0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (waitSt) begin
          state_nxt = S_MAC;
          relu_nxt  = cfg_relu;
          ic_nxt    = '0;
          oc_nxt    = '0;
          acc_nxt   = '0;
        end
      end

      S_MAC: begin
        inp_adr = ic;
        wgt_adr = WGTADRWIDTH'(oc) * WGT_ROW + WGTADRWIDTH'(ic);
        acc_nxt = acc + ACCWIDTH'(prod);
        ic_nxt  = ic + INPADRWIDTH'(1);
        if (ic == IC_LAST) begin
          state_nxt = S_STORE;
        end
      end

      S_STORE: begin
        res_we  = 1'b1;
        acc_nxt = '0;
        ic_nxt  = '0;
        if (oc == OC_LAST) begin
          state_nxt = S_DONE;
        end else begin
          oc_nxt    = oc + OUTADRWIDTH'(1);
          state_nxt = S_MAC;
        end
      end

      S_DONE: begin
        // Handshake follows the request level; a held request never restarts.
        waitFin = waitSt;
        if (!waitSt) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result memory: cleared by reset, written once per output in STORE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < OUTDATANUM; e++) begin
        result[e] <= '0;
      end
    end else if (res_we) begin
      result[oc] <= res_val;
    end
  end

  // Read table padded to the full address space; unused slots read zero.
  for (genvar g = 0; g < OUTSLOTS; g++) begin : g_rd
    if (g < OUTDATANUM) begin : g_used
      assign rd_table[g] = result[g];
    end else begin : g_unused
      assign rd_table[g] = '0;
    end
  end

  assign out_data = rd_table[out_adr];

endmodule

// File: tb/tb_aiu_mac_sequencer.sv
// Testbench for aiu_mac_sequencer: directed vector table, hand-written
// handshake/reset sequences and random jobs against a dot-product model.
module tb_aiu_mac_sequencer;

  logic clk;
  logic rst_n;
  logic wait_st;
  logic cfg_relu;
  logic [1:0] out_adr;
  bit sel;

  logic signed [31:0] inp_mem [8];
  logic signed [31:0] wgt_mem [32];

  // Default instance
  logic        wait_st_m, fin_m, busy_m;
  logic [2:0]  ia_m;
  logic [4:0]  wa_m;
  logic [31:0] id_m, wd_m, od_m;

  // Scaled instance with a non-power-of-two output count
  logic        wait_st_f, fin_f, busy_f;
  logic [2:0]  ia_f;
  logic [4:0]  wa_f;
  logic [31:0] id_f, wd_f, od_f;

  logic        fin_o, busy_o;
  logic [2:0]  ia_o;
  logic [4:0]  wa_o;
  logic [31:0] od_o;

  int checks   = 0;
  int failures = 0;

  assign wait_st_m = wait_st & ~sel;
  assign wait_st_f = wait_st & sel;
  assign id_m = inp_mem[ia_m];
  assign wd_m = wgt_mem[wa_m];
  assign id_f = inp_mem[ia_f];
  assign wd_f = wgt_mem[wa_f];

  always_comb begin
    if (sel) begin
      fin_o = fin_f; busy_o = busy_f; ia_o = ia_f; wa_o = wa_f; od_o = od_f;
    end else begin
      fin_o = fin_m; busy_o = busy_m; ia_o = ia_m; wa_o = wa_m; od_o = od_m;
    end
  end

  aiu_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .waitSt(wait_st_m), .waitFin(fin_m),
    .cfg_relu(cfg_relu), .inp_adr(ia_m), .inp_data(id_m),
    .wgt_adr(wa_m), .wgt_data(wd_m), .out_adr(out_adr),
    .out_data(od_m), .busy(busy_m)
  );

  aiu_mac_sequencer #(.FRACBITS(8), .OUTDATANUM(3)) dut_f (
    .clk(clk), .rst_n(rst_n), .waitSt(wait_st_f), .waitFin(fin_f),
    .cfg_relu(cfg_relu), .inp_adr(ia_f), .inp_data(id_f),
    .wgt_adr(wa_f), .wgt_data(wd_f), .out_adr(out_adr),
    .out_data(od_f), .busy(busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: saturated, scaled dot product from the memories as plain integers.
  function automatic logic [31:0] model(input int o, input bit relu, input bit f);
    int no = f ? 3 : 4;
    int fb = f ? 8 : 0;
    logic signed [127:0] s = '0;
    if (o >= no) return '0;
    for (int i = 0; i < 8; i++) s = s + 128'(inp_mem[i]) * 128'(wgt_mem[o*8+i]);
    s = s >>> fb;
    if (s > 128'sd2147483647) s = 128'sd2147483647;
    else if (s < -128'sd2147483648) s = -128'sd2147483648;
    if (relu && s < 0) s = '0;
    return s[31:0];
  endfunction

  task automatic fill_const(input logic [31:0] iv, input logic [31:0] wv, input bit ramp);
    for (int i = 0; i < 8; i++) inp_mem[i] = iv;
    for (int j = 0; j < 32; j++) wgt_mem[j] = ramp ? 32'(j / 8 + 1) : wv;
  endtask

  task automatic fill_random();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0: inp_mem[i] = $signed(32'($urandom_range(0, 200))) - 32'sd100;
        1: inp_mem[i] = $urandom;
        default: inp_mem[i] = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
      endcase
    end
    for (int j = 0; j < 32; j++) begin
      case (mode)
        0: wgt_mem[j] = $signed(32'($urandom_range(0, 200))) - 32'sd100;
        1: wgt_mem[j] = $urandom;
        default: wgt_mem[j] = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
      endcase
    end
  endtask

  task automatic check_results(input string tag, input bit relu);
    for (int a = 0; a < 4; a++) begin
      out_adr = 2'(a);
      #1;
      cmp($sformatf("%s_res%0d", tag, a), 64'(od_o), 64'(model(a, relu, sel)));
    end
  endtask

  task automatic check_idle(input string tag);
    #1;
    cmp({tag, "_busy"}, 64'(busy_o), 64'd0);
    cmp({tag, "_fin"}, 64'(fin_o), 64'd0);
    cmp({tag, "_adr"}, {ia_o, wa_o}, 64'd0);
    for (int a = 0; a < 4; a++) begin
      out_adr = 2'(a);
      #1;
      cmp($sformatf("%s_out%0d", tag, a), 64'(od_o), 64'd0);
    end
  endtask

  // One job. drop_k >= 0 releases the request after that many edges;
  // otherwise the request is held hold_extra cycles past the first waitFin.
  // k counts edges after the start edge; the value seen at observation k is
  // what the next edge samples, so first waitFin at k = LAT-1 means edge LAT.
  task automatic run_job(input string tag, input bit relu, input int drop_k, input int hold_extra);
    int no = sel ? 3 : 4;
    int lat = 1 + no * 9;
    int first_fin = -1;
    int fin_cnt = 0;
    int busy_low = -1;
    int adr_err = 0;
    int held = 0;
    int exp_i, exp_w;
    @(negedge clk);
    cfg_relu = relu;
    wait_st = 1'b1;
    @(posedge clk);
    #1 cfg_relu = ~relu;
    for (int k = 0; k < 200 && busy_low < 0; k++) begin
      @(negedge clk);
      exp_i = 0;
      exp_w = 0;
      if (k < no * 9 && (k % 9) < 8) begin
        exp_i = k % 9;
        exp_w = (k / 9) * 8 + exp_i;
      end
      if (ia_o !== 3'(exp_i) || wa_o !== 5'(exp_w)) adr_err++;
      if (!busy_o) begin
        busy_low = k;
      end else if (fin_o) begin
        fin_cnt++;
        if (first_fin < 0) first_fin = k;
        if (held >= hold_extra) wait_st = 1'b0;
        else held++;
      end
      if (k == drop_k) wait_st = 1'b0;
    end
    wait_st = 1'b0;
    cfg_relu = 1'b0;
    cmp({tag, "_first_fin"}, 64'(first_fin), 64'(drop_k >= 0 ? -1 : lat - 1));
    cmp({tag, "_fin_cycles"}, 64'(fin_cnt), 64'(drop_k >= 0 ? 0 : 1 + hold_extra));
    cmp({tag, "_busy_fall"}, 64'(busy_low), 64'(drop_k >= 0 ? lat : lat + hold_extra));
    cmp({tag, "_addr_errs"}, 64'(adr_err), 64'd0);
  endtask

  typedef struct {
    bit              sel;
    bit              relu;
    logic [31:0]     inp;
    logic [31:0]     wgt;
    bit              ramp;
    logic [3:0][31:0] expv;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'd1, 32'd0, 1'b1, {32'd32, 32'd24, 32'd16, 32'd8}};
    vecs[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'd2, 1'b0, {4{32'h7FFFFFFF}}};
    vecs[2] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, {4{32'h80000000}}};
    vecs[3] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, {4{32'h00000000}}};
    vecs[4] = '{1'b1, 1'b0, 32'd256, 32'd384, 1'b0, {32'd0, 32'd3072, 32'd3072, 32'd3072}};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFFFF00, 32'd384, 1'b0, {32'd0, 32'hFFFFF400, 32'hFFFFF400, 32'hFFFFF400}};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFFFF00, 32'd384, 1'b0, {32'd0, 32'd0, 32'd0, 32'd0}};

    rst_n = 1'b0;
    wait_st = 1'b1;
    cfg_relu = 1'b1;
    out_adr = '0;
    sel = 1'b0;
    fill_const(32'd0, 32'd0, 1'b0);

    // Reset holds everything idle even with a request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; check_idle("rst_m");
    sel = 1'b1; check_idle("rst_f");
    sel = 1'b0;
    wait_st = 1'b0;
    cfg_relu = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      fill_const(vecs[v].inp, vecs[v].wgt, vecs[v].ramp);
      run_job($sformatf("vec%0d", v), vecs[v].relu, -1, 0);
      for (int a = 0; a < 4; a++) begin
        out_adr = 2'(a);
        #1;
        cmp($sformatf("vec%0d_res%0d", v, a), 64'(od_o), 64'(vecs[v].expv[a]));
      end
    end
    sel = 1'b0;

    // Random back-to-back jobs: each replaces the previous results.
    for (int r = 0; r < 8; r++) begin
      bit relu;
      relu = 1'($urandom_range(0, 1));
      fill_random();
      run_job($sformatf("rnd%0d", r), relu, -1, 0);
      repeat (2) @(negedge clk);
      check_results($sformatf("rnd%0d", r), relu);
    end

    // Request dropped early: job completes silently.
    fill_const(32'd1, 32'd0, 1'b1);
    run_job("drop", 1'b0, 5, 0);
    check_results("drop", 1'b0);

    // Request held in DONE past the handshake: no restart.
    fill_random();
    run_job("hold", 1'b0, -1, 3);
    check_results("hold", 1'b0);

    // Reset in the middle of a job clears results and returns to idle.
    fill_random();
    @(negedge clk);
    wait_st = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    wait_st = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_const(32'd1, 32'd0, 1'b1);
    run_job("postrst", 1'b0, -1, 0);
    check_results("postrst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aiu_mac_sequencer.md
AIU_MAC_SEQUENCER -- requirements
Module: aiu_mac_sequencer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: signed word width of input, weight and result.
REQ-002 SHALL have parameter INPDATANUM, default 8: input words per job.
REQ-003 SHALL have parameter OUTDATANUM, default 4: result words per job.
REQ-004 SHALL have parameter FRACBITS, default 0: arithmetic right shift applied to each accumulator before saturation.
REQ-005 SHALL have ports as follows; INPADRWIDTH=clog2(INPDATANUM), OUTADRWIDTH=clog2(OUTDATANUM), WGTADRWIDTH=clog2(INPDATANUM*OUTDATANUM):
  clk  in  1  single clock, all logic on rising edge.
  rst_n  in  1  reset; synchronous, active-low.
  waitSt  in  1  job request from the AXI-stream interface; input buffer is full.
  waitFin  out  1  job complete, one-cycle handshake pulse.
  cfg_relu  in  1  ReLU enable, sampled when a job starts.
  inp_adr  out  INPADRWIDTH  input buffer read address.
  inp_data  in  DATAWIDTH  input buffer read data, combinational, same cycle.
  wgt_adr  out  WGTADRWIDTH  weight memory read address.
  wgt_data  in  DATAWIDTH  weight read data, combinational, same cycle.
  out_adr  in  OUTADRWIDTH  result read address.
  out_data  out  DATAWIDTH  result read data, combinational.
  busy  out  1  job in progress.

Function
REQ-006 SHALL implement FSM states IDLE, MAC, STORE, DONE, with input counter ic, output counter oc, signed accumulator acc and an OUTDATANUM-entry result memory.
REQ-007 IDLE: on waitSt=1, SHALL go to MAC, latch cfg_relu, and set ic=0, oc=0, acc=0.
REQ-008 MAC: SHALL drive inp_adr=ic and wgt_adr=oc*INPDATANUM+ic.
REQ-009 MAC: SHALL do acc <= acc + inp_data*wgt_data each cycle (signed); ic increments; at ic=INPDATANUM-1 SHALL go to STORE.
REQ-010 acc SHALL be 2*DATAWIDTH+clog2(INPDATANUM) bits, so it never overflows.
REQ-011 STORE: SHALL write res=sat(acc>>>FRACBITS) to result[oc].
REQ-012 sat SHALL clamp to the signed DATAWIDTH range [0x80000000, 0x7FFFFFFF] at default width.
REQ-013 If the latched relu=1 and res<0, STORE SHALL write 0 instead.
REQ-014 STORE SHALL clear acc and ic; if oc=OUTDATANUM-1 SHALL go to DONE, else oc increments and SHALL return to MAC.
REQ-015 DONE: waitFin SHALL equal waitSt, combinationally; when waitSt=0 SHALL go to IDLE.
REQ-016 waitFin SHALL be 0 in all states other than DONE.
REQ-017 Latency: waitFin SHALL first assert exactly 1+OUTDATANUM*(INPDATANUM+1) cycles after the IDLE edge that sampled waitSt=1 (37 at defaults).
REQ-018 waitSt falling during MAC/STORE SHALL NOT abort the job; results SHALL still be stored; DONE then returns to IDLE without a waitFin pulse.
REQ-019 inp_adr and wgt_adr SHALL be 0 in IDLE, STORE and DONE.
REQ-020 busy SHALL be 1 in MAC, STORE and DONE; 0 in IDLE.
REQ-021 out_data SHALL equal result[out_adr] in every state.
REQ-022 out_data SHALL return 0 for out_adr>=OUTDATANUM.
REQ-023 Results SHALL hold until overwritten by the next job's STORE.
REQ-024 A new job SHALL start only from IDLE; waitSt=1 held in DONE after the handshake SHALL NOT restart the job.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, ic=0, oc=0, acc=0, latched relu=0 and all result entries=0, in any state including mid-job.
REQ-026 While and after reset: waitFin=0, busy=0, inp_adr=0, wgt_adr=0, out_data=0.

Verification (defaults unless stated)
REQ-027 inp_data all 1, W[o][i]=o+1, waitSt held until waitFin -> waitFin one-cycle pulse at cycle 37; out_data[0..3]=8,16,24,32.
REQ-028 inp all 0x7FFFFFFF, weights 2 -> all results 0x7FFFFFFF; weights -2 -> 0x80000000; same with cfg_relu=1 -> 0.
REQ-029 rst_n=0 at cycle 10 of a job -> next cycle busy=0, waitFin=0, out_data=0 for adr 0..3; new job afterwards is correct.
REQ-030 waitSt dropped at cycle 5 -> waitFin never asserts, busy falls at cycle 38, results as in REQ-027.
REQ-031 Two back-to-back jobs with different inputs -> second results replace first; waitFin pulses once per job.
REQ-032 FRACBITS=8, inp 256, weights 384 -> results 3072; inp -256 -> -3072, or 0 with cfg_relu=1.
